// File: rtl/mul_acc_pkg.sv
// Shared widths, result record and saturating adder for the product accumulator.
package mul_acc_pkg;

  localparam int unsigned PROD_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 24;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] sum;
    logic                 sat;
    logic [CNT_W_DEF-1:0] count;
  } result_t;

  // Returns {overflow, value}; value clamps to 2^w-1 when the true sum exceeds it.
  function automatic logic [64:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] addend,
                                          input int unsigned w);
    logic [64:0] total;
    logic [64:0] limit;
    total = {1'b0, acc} + {1'b0, addend};
    limit = (65'd1 << w) - 65'd1;
    if (total > limit) sat_add = {1'b1, limit[63:0]};
    else               sat_add = {1'b0, total[63:0]};
  endfunction

endpackage

// File: rtl/mul_product_accumulator_fifo.sv
// Small synchronous result FIFO; occupancy feeds the upstream credit check.
module result_fifo
  import mul_acc_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type T = result_t,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  output T                 dout,
  output logic             empty,
  output logic [OCC_W-1:0] occupancy
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == OCC_W'(DEPTH));
  assign occupancy = count;
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign dout      = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) push |-> !full);

endmodule

// File: rtl/mul_product_accumulator.sv
// Tracks operand validity alongside a fixed-latency multiplier and sums each
// product group into a saturating accumulator, handing results off via a FIFO.
module mul_product_accumulator
  import mul_acc_pkg::*;
#(
  parameter int unsigned PROD_W  = PROD_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              op_valid,
  input  logic              op_last,
  output logic              op_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum_data,
  output logic              sum_sat,
  output logic [CNT_W-1:0]  sum_count
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned IF_W  = $clog2(MUL_LAT + 1);

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             sat;
    logic [CNT_W-1:0] count;
  } rec_t;

  logic [MUL_LAT-1:0] vld_sr;
  logic [MUL_LAT-1:0] last_sr;
  logic               issue;
  logic               p_valid;
  logic               p_last;
  logic [IF_W-1:0]    inflight;
  logic [OCC_W-1:0]   occupancy;
  logic               empty;

  logic [ACC_W-1:0]   acc;
  logic               sat_flag;
  logic [CNT_W-1:0]   cnt;
  logic [64:0]        add_res;
  logic               unused_hi;
  logic [ACC_W-1:0]   acc_next;
  logic               sat_next;
  logic [CNT_W-1:0]   cnt_next;

  rec_t               push_rec;
  rec_t               head;
  logic               push;

  assign issue   = op_valid & op_ready;
  assign p_valid = vld_sr[MUL_LAT-1];
  assign p_last  = last_sr[MUL_LAT-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= issue;
      last_sr[0] <= issue & op_last;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  // Every group close still in the pipe already holds a FIFO slot, so the
  // FIFO cannot overflow even though the multiplier never stalls.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MUL_LAT; i++) inflight = inflight + IF_W'(last_sr[i]);
  end

  assign op_ready = (32'(occupancy) + 32'(inflight)) < DEPTH;

  assign add_res   = sat_add(64'(acc), 64'(prod), ACC_W);
  assign acc_next  = add_res[ACC_W-1:0];
  assign unused_hi = ^add_res[63:ACC_W];
  assign sat_next  = sat_flag | add_res[64];
  assign cnt_next  = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      sat_flag <= 1'b0;
      cnt      <= '0;
    end else if (p_valid) begin
      if (p_last) begin
        acc      <= '0;
        sat_flag <= 1'b0;
        cnt      <= '0;
      end else begin
        acc      <= acc_next;
        sat_flag <= sat_next;
        cnt      <= cnt_next;
      end
    end
  end

  // The closing product is folded into the pushed record, not into acc.
  assign push = p_valid & p_last;

  always_comb begin
    push_rec       = '0;
    push_rec.sum   = acc_next;
    push_rec.sat   = sat_next;
    push_rec.count = cnt_next;
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .din       (push_rec),
    .pop       (sum_ready),
    .dout      (head),
    .empty     (empty),
    .occupancy (occupancy)
  );

  assign sum_valid = ~empty;
  assign sum_data  = head.sum;
  assign sum_sat   = head.sat;
  assign sum_count = head.count;

endmodule

// File: doc/mul_product_accumulator.md
Name: mul_product_accumulator

Overview:
Downstream consumer of pipeline_8_bit_multiplier. It tracks operand validity alongside the multiplier pipeline and accumulates the 16-bit products of one operand group into a wide sum. Completed sums go into a small result buffer and are handed off with a valid/ready handshake. Upstream flow control (op_ready) guarantees the result buffer never overflows, because the multiplier pipeline itself cannot stall.

Parameters:
PROD_W, 16, product width; matches multiplier out.
ACC_W, 24, accumulator/sum width; must be >= PROD_W.
MUL_LAT, 4, cycles from operands sampled at the multiplier to the matching product on out.
DEPTH, 2, result buffer entries.
CNT_W, 8, width of the per-group product counter.

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  asynchronous active-low reset.
op_valid  input  1  operands a/b are presented to the multiplier this cycle; meaningful only while op_ready=1.
op_last  input  1  qualifies op_valid: this operand pair closes the group.
op_ready  output  1  the source may issue an operand pair this cycle.
prod  input  PROD_W  multiplier out.
sum_valid  output  1  head result available.
sum_ready  input  1  consumer accepts the head result.
sum_data  output  ACC_W  group sum.
sum_sat  output  1  the group saturated.
sum_count  output  CNT_W  number of products in the group (wraps modulo 2^CNT_W).

Behaviour:
- Issue: issue = op_valid & op_ready. The source must not change a/b without issue; pairs presented while op_ready=0 are ignored.
- Tracking: a MUL_LAT-deep shift register carries {issue, op_last}. Its tail, {p_valid, p_last}, aligns with prod.
- Accumulate: on p_valid, acc <= sat(acc + prod) and cnt <= cnt + 1. Addition is unsigned. When the true sum exceeds 2^ACC_W-1, acc holds all-ones and sat_flag becomes sticky 1 for the group.
- Close: on p_valid & p_last, push {final acc, final sat, final cnt} into the FIFO, including the current product. In the same cycle clear acc, sat_flag and cnt to 0, so the next group starts clean with no bubble.
- FIFO: DEPTH entries. The head drives sum_data, sum_sat and sum_count. sum_valid = !empty. Pop on sum_valid & sum_ready. A push and a pop in the same cycle are both honoured. sum_* outputs stay stable while sum_valid & !sum_ready.
- Credit: inflight = number of last-flagged entries in the shift register. op_ready = (occupancy + inflight) < DEPTH. This is a registered/combinational mix, with no combinational path from sum_ready to op_ready. Consequently, a push never occurs into a full FIFO.
- Latency: the sum is visible (sum_valid=1) on the cycle after the last product is accumulated, i.e. MUL_LAT+1 cycles after the last issue.
- Reset (any time, including mid-group):
  - shift register, acc, cnt, sat_flag and FIFO are cleared.
  - sum_valid=0, sum_data=0, sum_sat=0, sum_count=0.
  - op_ready=1.
  - Products still emerging from the multiplier after reset are ignored, because their valid bits were cleared.
- Single-product group: a pair issued with op_last=1 gives sum = prod and count = 1.
- Consecutive groups: back-to-back last pairs are legal while op_ready stays high.

Decomposition:
- Package mul_acc_pkg holds:
  - default widths (PROD_W, ACC_W, CNT_W);
  - the result record typedef {sum, sat, count};
  - the saturating-add function.
- One natural sub-module, result_fifo: parameterised DEPTH, synchronous FIFO with async active-low reset, exposing an occupancy output for the credit logic.

Test Plan:
- Four pairs (32,32),(12,74),(12,24),(43,7) issued back-to-back, last on the 4th; sum_ready=1 -> one result: sum_data=2501 (1024+888+288+301), sum_count=4, sum_sat=0, sum_valid high MUL_LAT+1 cycles after the 4th issue.
- Single pair (255,255) with op_last -> sum_data=65025, count=1. Followed immediately by (2,3) with last -> second result 6, no bubble between groups.
- ACC_W=17, three pairs (255,255) in one group -> sum_data=131071, sum_sat=1, count=3. The next group (1,1) gives sum=1, sat=0.
- sum_ready=0 while issuing three single-pair groups:
  - op_ready drops after the 2nd issue;
  - the 3rd group is accepted only once a result is popped;
  - results return in order and are unchanged while stalled.
- rstn pulsed low mid-group after 2 of 4 pairs -> all outputs 0 and op_ready=1. The stale products are ignored, and a new group (5,5) yields sum=25, count=1.
- Simultaneous push and pop with the FIFO full-minus-one -> occupancy unchanged and data ordering preserved.
